// File: rtl/frame_scan_pipe.sv
// Pixel scan generator and framebuffer writer: sweeps (x, y) through an external shader, aligns results, writes SRAM.
// Optional macro SWAP_ON_VSYNC_EN: the double-buffer swap waits for a synchronised vsync rising edge.
module frame_scan_pipe #(
   parameter int H_RES      = 800,
   parameter int V_RES      = 600,
   parameter int PIPE_DEPTH = 3,
   parameter int XW         = 10,
   parameter int YW         = 10,
   parameter int ADDR_W     = 19
) (
   input  logic              clk,
   input  logic              reset_btn,
   input  logic              draw_req,
   input  logic              vsync,
   output logic [XW-1:0]     pix_x,
   output logic [YW-1:0]     pix_y,
   output logic              pix_valid,
   output logic              pipe_stall,
   input  logic [23:0]       shade_rgb,
   output logic              sram_wr_en,
   output logic [ADDR_W-1:0] sram_wr_addr,
   output logic [31:0]       sram_wr_data,
   input  logic              sram_wr_ready,
   output logic              wr_addr_offset,
   output logic              rd_addr_offset,
   output logic              busy,
   output logic              frame_done
);

   // state   | meaning
   // S_IDLE  | waiting for draw_req
   // S_SCAN  | issuing one pixel per advancing cycle
   // S_DRAIN | flushing the pipeline until the last write is accepted
   // S_SWAP  | toggling buffer offsets, pulsing frame_done
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_SWAP  = 2'd3;

   if (longint'(H_RES) * longint'(V_RES) > (longint'(1) << ADDR_W)) begin : g_addr_chk
      $error("frame_scan_pipe: H_RES*V_RES does not fit in ADDR_W");
   end
   if (PIPE_DEPTH < 1) begin : g_depth_chk
      $error("frame_scan_pipe: PIPE_DEPTH must be at least 1");
   end

   logic [1:0]            state;
   logic [XW-1:0]         x_cnt;
   logic [YW-1:0]         y_cnt;
   logic [ADDR_W-1:0]     addr_cnt;
   logic [PIPE_DEPTH-1:0] v_pipe;
   logic [ADDR_W-1:0]     a_pipe [PIPE_DEPTH];
   logic                  advance;
   logic                  last_pix;
   logic                  pipe_empty;
   logic                  swap_go;

   assign advance    = !(sram_wr_en && !sram_wr_ready);
   assign pipe_stall = !advance;
   assign pix_valid  = v_pipe[0];
   assign busy       = (state != S_IDLE);
   assign last_pix   = (x_cnt == XW'(H_RES - 1)) && (y_cnt == YW'(V_RES - 1));
   assign pipe_empty = (v_pipe == '0) && !sram_wr_en;

`ifdef SWAP_ON_VSYNC_EN
   logic vs_s1, vs_s2, vs_s3;

   always_ff @(posedge clk) begin
      if (reset_btn) begin
         vs_s1 <= 1'b0;
         vs_s2 <= 1'b0;
         vs_s3 <= 1'b0;
      end else begin
         vs_s1 <= vsync;
         vs_s2 <= vs_s1;
         vs_s3 <= vs_s2;
      end
   end

   assign swap_go = vs_s2 && !vs_s3;
`else
   logic unused_vsync;
   assign unused_vsync = vsync;
   assign swap_go      = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset_btn) begin
         state          <= S_IDLE;
         x_cnt          <= '0;
         y_cnt          <= '0;
         addr_cnt       <= '0;
         v_pipe         <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) a_pipe[i] <= '0;
         pix_x          <= '0;
         pix_y          <= '0;
         sram_wr_en     <= 1'b0;
         sram_wr_addr   <= '0;
         sram_wr_data   <= '0;
         wr_addr_offset <= 1'b1;
         rd_addr_offset <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         // Every stage, including the shader outside, moves only on advance.
         if (advance) begin
            v_pipe[0] <= (state == S_SCAN);
            if (state == S_SCAN) begin
               pix_x     <= x_cnt;
               pix_y     <= y_cnt;
               a_pipe[0] <= addr_cnt;
            end
            for (int i = 1; i < PIPE_DEPTH; i++) begin
               v_pipe[i] <= v_pipe[i-1];
               a_pipe[i] <= a_pipe[i-1];
            end
            sram_wr_en <= v_pipe[PIPE_DEPTH-1];
            if (v_pipe[PIPE_DEPTH-1]) begin
               sram_wr_addr <= a_pipe[PIPE_DEPTH-1];
               sram_wr_data <= {8'h00, shade_rgb};
            end
         end

         case (state)
            S_IDLE: begin
               if (draw_req) begin
                  state    <= S_SCAN;
                  x_cnt    <= '0;
                  y_cnt    <= '0;
                  addr_cnt <= '0;
               end
            end
            S_SCAN: begin
               if (advance) begin
                  addr_cnt <= addr_cnt + ADDR_W'(1);
                  if (x_cnt == XW'(H_RES - 1)) begin
                     x_cnt <= '0;
                     y_cnt <= y_cnt + YW'(1);
                  end else begin
                     x_cnt <= x_cnt + XW'(1);
                  end
                  if (last_pix) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pipe_empty) state <= S_SWAP;
            end
            default: begin
               if (swap_go) begin
                  wr_addr_offset <= !wr_addr_offset;
                  rd_addr_offset <= !rd_addr_offset;
                  frame_done     <= 1'b1;
                  state          <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_scan_pipe.sv
// Bench for frame_scan_pipe on a 4x3 frame with a 2-deep shader model; checks writes against an address-order reference.
module tb_frame_scan_pipe;
   localparam int H_T  = 4;
   localparam int V_T  = 3;
   localparam int PD_T = 2;
   localparam int XW_T = 10;
   localparam int YW_T = 10;
   localparam int AW_T = 19;
   localparam int NPIX = H_T * V_T;

   logic              clk;
   logic              reset_btn;
   logic              draw_req;
   logic              vsync;
   logic [XW_T-1:0]   pix_x;
   logic [YW_T-1:0]   pix_y;
   logic              pix_valid;
   logic              pipe_stall;
   logic [23:0]       shade_rgb;
   logic              sram_wr_en;
   logic [AW_T-1:0]   sram_wr_addr;
   logic [31:0]       sram_wr_data;
   logic              sram_wr_ready;
   logic              wr_addr_offset;
   logic              rd_addr_offset;
   logic              busy;
   logic              frame_done;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          seed    = 0;
   int          cyc     = 0;
   int          fd_cnt;
   int          first_pv_cyc;
   int          first_pv_x;
   int          first_pv_y;
   int          wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   int          wr_cyc_q  [$];
   logic        vs_auto;
   logic        vs_man;
   logic [3:0]  vph = '0;
   logic [23:0] sh_q;
   logic        exp_rd;

   frame_scan_pipe #(
      .H_RES(H_T), .V_RES(V_T), .PIPE_DEPTH(PD_T), .XW(XW_T), .YW(YW_T), .ADDR_W(AW_T)
   ) dut (
      .clk(clk), .reset_btn(reset_btn), .draw_req(draw_req), .vsync(vsync),
      .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pipe_stall(pipe_stall),
      .shade_rgb(shade_rgb), .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
      .sram_wr_data(sram_wr_data), .sram_wr_ready(sram_wr_ready),
      .wr_addr_offset(wr_addr_offset), .rd_addr_offset(rd_addr_offset),
      .busy(busy), .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Shader stand-in: one register stage (PD_T-1 advances) that freezes with the pipe.
   assign shade_rgb = sh_q;
   always @(posedge clk) begin
      if (!pipe_stall) sh_q <= 24'((int'(pix_y) * H_T + int'(pix_x)) ^ seed);
   end

   initial begin
      vs_auto = 1'b1;
      vs_man  = 1'b0;
      vsync   = 1'b0;
      forever begin
         @(negedge clk);
         vph   = vph + 4'd1;
         vsync = vs_auto ? vph[3] : vs_man;
      end
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (pix_valid && first_pv_cyc < 0) begin
         first_pv_cyc = cyc;
         first_pv_x   = int'(pix_x);
         first_pv_y   = int'(pix_y);
      end
      if (sram_wr_en && sram_wr_ready) begin
         wr_addr_q.push_back(int'(sram_wr_addr));
         wr_data_q.push_back(sram_wr_data);
         wr_cyc_q.push_back(cyc);
      end
      if (frame_done) fd_cnt = fd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input int a);
      return {8'h00, 24'(a ^ seed)};
   endfunction

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      fd_cnt       = 0;
      first_pv_cyc = -1;
      first_pv_x   = -1;
      first_pv_y   = -1;
   endtask

   task automatic start_frame();
      @(negedge clk);
      draw_req = 1'b1;
      @(negedge clk);
      draw_req = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (fd_cnt >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_wr(input int a, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (sram_wr_en && sram_wr_addr == AW_T'(a)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Reference: each frame writes addresses 0..NPIX-1 in order, data = shader(address).
   task automatic check_writes(input string tag, input int nframes);
      chk({tag, "_count"}, wr_addr_q.size(), nframes * NPIX);
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         chk({tag, "_addr"}, wr_addr_q[i], i % NPIX);
         chk({tag, "_data"}, wr_data_q[i], exp_data(i % NPIX));
      end
   endtask

   initial begin
      bit ok;
      bit rd_before;
      reset_btn     = 1'b1;
      draw_req      = 1'b0;
      sram_wr_ready = 1'b1;
      clear_mon();
      repeat (3) @(negedge clk);

      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_x", pix_x, 0);
      chk("rst_pix_y", pix_y, 0);
      chk("rst_wr_en", sram_wr_en, 0);
      chk("rst_wr_addr", sram_wr_addr, 0);
      chk("rst_wr_data", sram_wr_data, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_offsets", {wr_addr_offset, rd_addr_offset}, 2'b10);
      chk("rst_busy", busy, 0);
      chk("rst_stall", pipe_stall, 0);
      reset_btn = 1'b0;
      exp_rd    = 1'b0;
      @(negedge clk);

      // Single frame, ready always high.
      clear_mon();
      seed = int'($urandom_range(0, 24'hFFFFFF));
      start_frame();
      wait_frames(1, 300, ok);
      chk("t1_frame_done_seen", ok, 1);
      repeat (3) @(negedge clk);
      chk("t1_single_pulse", fd_cnt, 1);
      check_writes("t1", 1);
      if (wr_cyc_q.size() == NPIX) begin
         chk("t1_first_latency", wr_cyc_q[0] - first_pv_cyc, PD_T);
         chk("t1_back_to_back", wr_cyc_q[NPIX-1] - wr_cyc_q[0], NPIX - 1);
      end
      exp_rd = !exp_rd;
      chk("t1_rd_offset", rd_addr_offset, exp_rd);
      chk("t1_wr_offset", wr_addr_offset, !exp_rd);
      chk("t1_idle", busy, 0);

      // Back-pressure held for 5 cycles while address 5 is presented.
      clear_mon();
      seed = int'($urandom_range(0, 24'hFFFFFF));
      start_frame();
      wait_wr(5, 100, ok);
      chk("t2_reach_addr5", ok, 1);
      sram_wr_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t2_hold_addr", sram_wr_addr, 5);
         chk("t2_hold_data", sram_wr_data, exp_data(5));
         chk("t2_hold_pix_x", pix_x, (5 + PD_T) % H_T);
         chk("t2_hold_pix_y", pix_y, (5 + PD_T) / H_T);
         chk("t2_hold_valid", pix_valid, 1);
         chk("t2_stall", pipe_stall, 1);
      end
      sram_wr_ready = 1'b1;
      wait_frames(1, 300, ok);
      chk("t2_frame_done_seen", ok, 1);
      check_writes("t2", 1);
      exp_rd = !exp_rd;
      chk("t2_rd_offset", rd_addr_offset, exp_rd);

      // Random back-pressure over a whole frame.
      clear_mon();
      seed = int'($urandom_range(0, 24'hFFFFFF));
      start_frame();
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         sram_wr_ready = ($urandom_range(0, 3) != 0);
         if (fd_cnt >= 1) begin
            ok = 1'b1;
            break;
         end
      end
      sram_wr_ready = 1'b1;
      chk("t_rand_frame_done_seen", ok, 1);
      check_writes("t_rand", 1);
      exp_rd = !exp_rd;
      chk("t_rand_rd_offset", rd_addr_offset, exp_rd);

      // draw_req held high: two frames back to back, offsets back where they started.
      clear_mon();
      rd_before = rd_addr_offset;
      @(negedge clk);
      draw_req = 1'b1;
      wait_frames(1, 300, ok);
      chk("t3_first_done", ok, 1);
      chk("t3_restart_busy", busy, 1);
      draw_req = 1'b0;
      wait_frames(2, 300, ok);
      chk("t3_second_done", ok, 1);
      repeat (20) @(negedge clk);
      chk("t3_pulses", fd_cnt, 2);
      check_writes("t3", 2);
      chk("t3_rd_offset", rd_addr_offset, rd_before);
      chk("t3_wr_offset", wr_addr_offset, !rd_before);
      chk("t3_idle", busy, 0);

      // Reset mid-frame at write address 7.
      clear_mon();
      seed = int'($urandom_range(0, 24'hFFFFFF));
      start_frame();
      wait_wr(7, 100, ok);
      chk("t4_reach_addr7", ok, 1);
      reset_btn = 1'b1;
      @(negedge clk);
      reset_btn = 1'b0;
      exp_rd    = 1'b0;
      chk("t4_pix_valid", pix_valid, 0);
      chk("t4_pix_xy", {pix_x, pix_y}, 0);
      chk("t4_wr_en", sram_wr_en, 0);
      chk("t4_wr_addr", sram_wr_addr, 0);
      chk("t4_wr_data", sram_wr_data, 0);
      chk("t4_offsets", {wr_addr_offset, rd_addr_offset}, 2'b10);
      chk("t4_busy", busy, 0);
      chk("t4_no_swap", fd_cnt, 0);
      clear_mon();
      start_frame();
      wait_frames(1, 300, ok);
      chk("t4_restart_done", ok, 1);
      chk("t4_first_pix", {first_pv_x[15:0], first_pv_y[15:0]}, 0);
      check_writes("t4", 1);
      exp_rd = !exp_rd;
      chk("t4_rd_offset", rd_addr_offset, exp_rd);

      // draw_req during SCAN is ignored.
      clear_mon();
      seed = int'($urandom_range(0, 24'hFFFFFF));
      start_frame();
      repeat (4) @(negedge clk);
      chk("t5_in_scan", busy, 1);
      draw_req = 1'b1;
      @(negedge clk);
      draw_req = 1'b0;
      wait_frames(1, 300, ok);
      chk("t5_done", ok, 1);
      repeat (30) @(negedge clk);
      chk("t5_pulses", fd_cnt, 1);
      check_writes("t5", 1);
      chk("t5_idle", busy, 0);
      exp_rd = !exp_rd;
      chk("t5_rd_offset", rd_addr_offset, exp_rd);

      vs_auto = 1'b0;
      vs_man  = 1'b0;
      repeat (5) @(negedge clk);
      clear_mon();
      seed = int'($urandom_range(0, 24'hFFFFFF));
      start_frame();
`ifdef SWAP_ON_VSYNC_EN
      // Swap waits for vsync, then lands on the 3rd clock edge after vsync rises.
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (wr_addr_q.size() >= NPIX) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t6_writes_done", ok, 1);
      repeat (100) @(negedge clk);
      chk("t6_no_swap", fd_cnt, 0);
      chk("t6_busy_wait", busy, 1);
      chk("t6_rd_held", rd_addr_offset, exp_rd);
      vs_man = 1'b1;
      @(negedge clk);
      chk("t6_edge1", frame_done, 0);
      @(negedge clk);
      chk("t6_edge2", frame_done, 0);
      @(negedge clk);
      chk("t6_edge3", frame_done, 1);
      exp_rd = !exp_rd;
      chk("t6_rd_offset", rd_addr_offset, exp_rd);
      vs_man = 1'b0;
`else
      // Without the vsync option, vsync held low must not delay the swap.
      wait_frames(1, 100, ok);
      chk("t6_no_vsync_needed", ok, 1);
      exp_rd = !exp_rd;
      chk("t6_rd_offset", rd_addr_offset, exp_rd);
`endif
      repeat (3) @(negedge clk);
      check_writes("t6", 1);
      vs_auto = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
